// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one shared full-adder slice processes the operands
// LSB first, one bit per clock, then reports result, carry/no-borrow and overflow.
module serial_add_sub #(
    parameter int WIDTH = 4,
    parameter int MODE  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_part;
    logic [CW-1:0]     r_cnt;
    logic              r_c;
    logic              r_busy;
    logic              r_done;
    logic [WIDTH-1:0]  r_result;
    logic              r_carry_out;
    logic              r_overflow;
    logic              w_op_add;
    logic              w_load;
    logic              w_last;
    logic              w_sum;
    logic              w_c_next;

    // Effective operation is fixed at elaboration unless runtime select is enabled.
    generate
        if (MODE == 1) begin : g_add_only
            logic w_sel_unused;
            assign w_sel_unused = sel;
            assign w_op_add     = 1'b1;
        end else if (MODE == 0) begin : g_sub_only
            logic w_sel_unused;
            assign w_sel_unused = sel;
            assign w_op_add     = 1'b0;
        end else begin : g_runtime
            assign w_op_add = sel;
        end
    endgenerate

    assign w_load   = (r_state == S_IDLE) && start;
    assign w_last   = (r_state == S_SHIFT) && (r_cnt == LAST_BIT);
    assign w_sum    = r_a[0] ^ r_b[0] ^ r_c;
    assign w_c_next = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_SHIFT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (r_cnt == LAST_BIT) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_SHIFT;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Status outputs registered from the next state so they align with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_next == S_SHIFT);
            r_done <= (w_state_next == S_DONE);
        end
    end

    // Serial datapath: operand load, one full-adder step per cycle, final flag capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a         <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_part      <= {WIDTH{1'b0}};
            r_cnt       <= {CW{1'b0}};
            r_c         <= 1'b0;
            r_result    <= {WIDTH{1'b0}};
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_load) begin
            // Subtraction is in0 + ~in1 + 1, so invert B and preset the carry.
            r_a   <= in0;
            r_b   <= in1 ^ {WIDTH{~w_op_add}};
            r_c   <= ~w_op_add;
            r_cnt <= {CW{1'b0}};
        end else if (r_state == S_SHIFT) begin
            r_a    <= {1'b0, r_a[WIDTH-1:1]};
            r_b    <= {1'b0, r_b[WIDTH-1:1]};
            r_c    <= w_c_next;
            r_part <= {w_sum, r_part[WIDTH-1:1]};
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) begin
                // r_c is the carry into the MSB here; w_c_next is the carry out of it.
                r_result    <= {w_sum, r_part[WIDTH-1:1]};
                r_carry_out <= w_c_next;
                r_overflow  <= r_c ^ w_c_next;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule
